// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low segment codes {a..g}, blank code,
// and the scan FSM state type. Used by both the encoder and the scan decoder.
package sevenseg_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK_N = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_N_0 = 7'h01;
    localparam logic [SEG_W-1:0] SEG_N_1 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_N_2 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_N_3 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_N_4 = 7'h4C;
    localparam logic [SEG_W-1:0] SEG_N_5 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_N_6 = 7'h20;
    localparam logic [SEG_W-1:0] SEG_N_7 = 7'h0F;
    localparam logic [SEG_W-1:0] SEG_N_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_N_9 = 7'h04;
    localparam logic [SEG_W-1:0] SEG_N_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_N_B = 7'h60;
    localparam logic [SEG_W-1:0] SEG_N_C = 7'h31;
    localparam logic [SEG_W-1:0] SEG_N_D = 7'h42;
    localparam logic [SEG_W-1:0] SEG_N_E = 7'h30;
    localparam logic [SEG_W-1:0] SEG_N_F = 7'h38;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } scan_state_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational inverse of the hex encoder: active-low segment pattern to nibble.
// Any pattern outside the 16 legal codes reports illegal with nibble 0.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_n,
    output logic [3:0]       nibble,
    output logic             illegal
);

    always_comb begin
        nibble  = 4'h0;
        illegal = 1'b0;
        case (seg_n)
            SEG_N_0: nibble = 4'h0;
            SEG_N_1: nibble = 4'h1;
            SEG_N_2: nibble = 4'h2;
            SEG_N_3: nibble = 4'h3;
            SEG_N_4: nibble = 4'h4;
            SEG_N_5: nibble = 4'h5;
            SEG_N_6: nibble = 4'h6;
            SEG_N_7: nibble = 4'h7;
            SEG_N_8: nibble = 4'h8;
            SEG_N_9: nibble = 4'h9;
            SEG_N_A: nibble = 4'hA;
            SEG_N_B: nibble = 4'hB;
            SEG_N_C: nibble = 4'hC;
            SEG_N_D: nibble = 4'hD;
            SEG_N_E: nibble = 4'hE;
            SEG_N_F: nibble = 4'hF;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus, captures each digit once it
// has been stable long enough, and presents the assembled value on valid/ready.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEG_W-1:0]        seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int BUS_W = NUM_DIGITS + SEG_W;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    logic [BUS_W-1:0]      sync1_reg, sync2_reg, prev_reg;
    logic [SEG_W-1:0]      seg_bus;
    logic [NUM_DIGITS-1:0] an_low;
    logic [3:0]            dec_nibble;
    logic                  dec_illegal;

    scan_state_t           state_reg;
    logic [CNT_W-1:0]      cnt_reg, cnt_inc, run_len;
    logic                  same, onehot, hold, capture;
    logic [IDX_W-1:0]      cap_idx;

    logic [3:0]            slot_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_err_reg, captured_reg, hit;
    logic [4*NUM_DIGITS-1:0] slot_flat;
    logic                  frame_done;

    // Idle level of the synchronizer is "blank, no digit selected".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
            prev_reg  <= '1;
        end else begin
            sync1_reg <= {an_n, seg_n};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign seg_bus = sync2_reg[SEG_W-1:0];
    assign an_low  = ~sync2_reg[BUS_W-1:SEG_W];

    sevenseg_pattern_decode u_decode (
        .seg_n   (seg_bus),
        .nibble  (dec_nibble),
        .illegal (dec_illegal)
    );

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) cap_idx = IDX_W'(i);
        end
    end

    assign onehot  = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    assign same    = (sync2_reg == prev_reg);
    assign hold    = (state_reg == LOCKED) && same;
    assign cnt_inc = (cnt_reg == CNT_TARGET) ? cnt_reg : cnt_reg + 1'b1;
    // Length of the current run of identical samples, including this one.
    assign run_len = (state_reg != IDLE && same) ? cnt_inc : CNT_W'(1);
    assign capture = onehot && !hold && (run_len == CNT_TARGET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (hold) begin
            state_reg <= LOCKED;
        end else if (!onehot) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (capture) begin
            state_reg <= LOCKED;
            cnt_reg   <= run_len;
        end else begin
            state_reg <= SETTLE;
            cnt_reg   <= run_len;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign hit[gi] = capture && (cap_idx == IDX_W'(gi));
            assign slot_flat[4*gi +: 4] = slot_reg[gi];
        end
    endgenerate

    assign frame_done = &captured_reg;

    // A capture landing on the completion cycle belongs to the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captured_reg <= '0;
            slot_err_reg <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) slot_reg[i] <= 4'h0;
        end else begin
            captured_reg <= (frame_done ? '0 : captured_reg) | hit;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (hit[i]) begin
                    slot_reg[i]     <= dec_nibble;
                    slot_err_reg[i] <= dec_illegal;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= '0;
            overrun   <= 1'b0;
        end else if (frame_done) begin
            out_valid <= 1'b1;
            out_value <= slot_flat;
            out_err   <= slot_err_reg;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: scans digit patterns onto the bus, queues the
// expected frames and compares them as the DUT hands them over.
module tb_sevenseg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    seg_n = 7'h7F;
    logic [ND-1:0] an_n = '1;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [4*ND-1:0] out_value;
    logic [ND-1:0] out_err;
    logic          overrun;

    int n_chk = 0;
    int n_fail = 0;
    int n_xfer = 0;
    logic [19:0] sb_q [$];
    logic [19:0] sb_item;

    sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [6:0] enc(input int v);
        case (v)
            0: enc = 7'h01;  1: enc = 7'h4F;  2: enc = 7'h12;  3: enc = 7'h06;
            4: enc = 7'h4C;  5: enc = 7'h24;  6: enc = 7'h20;  7: enc = 7'h0F;
            8: enc = 7'h00;  9: enc = 7'h04;  10: enc = 7'h08; 11: enc = 7'h60;
            12: enc = 7'h31; 13: enc = 7'h42; 14: enc = 7'h30; default: enc = 7'h38;
        endcase
    endfunction

    // All drive tasks enter and leave one time unit after a rising edge.
    task automatic scan_digit(input int idx, input logic [6:0] pat, input int dwell);
        logic [ND-1:0] one = 1;
        an_n  = ~(one << idx);
        seg_n = pat;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int cycles);
        an_n  = '1;
        seg_n = 7'h7F;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
                sb_item = sb_q.pop_front();
                chk("sb_value", 32'(out_value), 32'(sb_item[15:0]));
                chk("sb_err", 32'(out_err), 32'(sb_item[19:16]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_value", 32'(out_value), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        blank(4);

        // Basic scan
        base = n_xfer;
        sb_q.push_back({4'b0000, 16'h0124});
        scan_digit(0, 7'h4C, 10);
        scan_digit(1, 7'h12, 10);
        scan_digit(2, 7'h4F, 10);
        scan_digit(3, 7'h01, 10);
        blank(5);
        chk("t1_xfers", 32'(n_xfer - base), 32'd1);

        // Blank pattern on digit 2 is an illegal code
        base = n_xfer;
        sb_q.push_back({4'b0100, 16'hF0A5});
        scan_digit(0, enc(5), 10);
        scan_digit(1, enc(10), 10);
        scan_digit(2, 7'h7F, 10);
        scan_digit(3, enc(15), 10);
        blank(5);
        chk("t2_xfers", 32'(n_xfer - base), 32'd1);

        // Glitching digit 1 never settles
        base = n_xfer;
        scan_digit(0, enc(3), 10);
        for (int k = 0; k < 10; k++) begin
            scan_digit(1, enc(7), 2);
            scan_digit(1, 7'h0E, 1);
        end
        scan_digit(2, enc(9), 10);
        scan_digit(3, enc(12), 10);
        blank(5);
        chk("t3_glitch_xfers", 32'(n_xfer - base), 32'd0);
        chk("t3_glitch_valid", 32'(out_valid), 32'd0);
        sb_q.push_back({4'b0000, 16'hC973});
        scan_digit(1, enc(7), 10);
        blank(5);
        chk("t3_clean_xfers", 32'(n_xfer - base), 32'd1);

        // Overrun with consumer stalled
        base = n_xfer;
        out_ready = 1'b0;
        scan_digit(0, enc(1), 10);
        scan_digit(1, enc(2), 10);
        scan_digit(2, enc(3), 10);
        scan_digit(3, enc(4), 10);
        chk("t4_f1_valid", 32'(out_valid), 32'd1);
        chk("t4_f1_value", 32'(out_value), 32'h4321);
        chk("t4_f1_overrun", 32'(overrun), 32'd0);
        sb_q.push_back({4'b0000, 16'hEDB8});
        scan_digit(0, enc(8), 10);
        scan_digit(1, enc(11), 10);
        scan_digit(2, enc(13), 10);
        scan_digit(3, enc(14), 10);
        chk("t4_f2_valid", 32'(out_valid), 32'd1);
        chk("t4_f2_value", 32'(out_value), 32'hEDB8);
        chk("t4_f2_overrun", 32'(overrun), 32'd1);
        chk("t4_stall_xfers", 32'(n_xfer - base), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_valid_drop", 32'(out_valid), 32'd0);
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);
        chk("t4_xfers", 32'(n_xfer - base), 32'd1);
        blank(5);

        // Two strobes low: no capture; single strobe then captures
        base = n_xfer;
        scan_digit(1, enc(6), 10);
        scan_digit(2, enc(0), 10);
        scan_digit(3, enc(10), 10);
        an_n  = 4'b1100;
        seg_n = enc(5);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_multi_xfers", 32'(n_xfer - base), 32'd0);
        chk("t5_multi_valid", 32'(out_valid), 32'd0);
        sb_q.push_back({4'b0000, 16'hA06B});
        an_n  = 4'b1110;
        seg_n = enc(11);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t5_latency", 32'(lat), 32'(SC + 3));
        blank(5);
        chk("t5_xfers", 32'(n_xfer - base), 32'd1);

        // Reset mid-frame
        base = n_xfer;
        scan_digit(0, enc(1), 10);
        scan_digit(1, enc(1), 10);
        scan_digit(2, enc(1), 10);
        an_n  = '1;
        seg_n = 7'h7F;
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_value", 32'(out_value), 32'd0);
        chk("t6_rst_err", 32'(out_err), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        blank(3);
        scan_digit(3, enc(15), 10);
        blank(5);
        chk("t6_partial_xfers", 32'(n_xfer - base), 32'd0);
        chk("t6_partial_valid", 32'(out_valid), 32'd0);
        sb_q.push_back({4'b0000, 16'hFCDE});
        scan_digit(0, enc(14), 10);
        scan_digit(1, enc(13), 10);
        scan_digit(2, enc(12), 10);
        scan_digit(3, enc(15), 10);
        blank(5);
        chk("t6_xfers", 32'(n_xfer - base), 32'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
